// File: rtl/ifmap_loader.sv
// Pixel-stream to BRAM loader: packs four 8-bit pixels per 32-bit word and
// writes each full (or final zero-padded partial) word in the next cycle.

module ifmap_lane (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       load,
   input  logic [7:0] data,
   output logic [7:0] q
);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)      q <= '0;
      else if (clr)  q <= '0;
      else if (load) q <= data;
   end
endmodule

module ifmap_loader #(
   parameter int unsigned NUM_PIX   = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0,
   parameter logic [31:0] ADDR_INC  = 32'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        done,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [7:0]  s_data,
   output logic [31:0] BRAM_IF_ADDR,
   output logic [3:0]  BRAM_IF_WE,
   output logic        BRAM_IF_EN,
   output logic [31:0] BRAM_IF_DIN
);
   localparam int          NUM_LANES = 4;
   localparam int          VEC_W     = 8;
   localparam logic [16:0] LAST_PIX  = 17'(NUM_PIX - 1);
   localparam logic [16:0] PIX_TOTAL = 17'(NUM_PIX);

   typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

   state_t                          state, state_nxt;
   logic [16:0]                     pix_cnt;
   logic [1:0]                      lane;
   logic [31:0]                     word_addr;
   logic [NUM_LANES-1:0][VEC_W-1:0] pack;
   logic                            accept, init, flush;

   assign accept = (state == LOAD) && s_valid;
   assign init   = start && ((state == IDLE) || (state == DONE));
   assign flush  = (state == WRITE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pix_cnt   <= '0;
         lane      <= '0;
         word_addr <= '0;
      end else if (init) begin
         pix_cnt   <= '0;
         lane      <= '0;
         word_addr <= BASE_ADDR;
      end else if (accept) begin
         pix_cnt   <= pix_cnt + 17'd1;
         lane      <= lane + 2'd1;
      end else if (flush) begin
         // address wraps naturally at 2^32
         word_addr <= word_addr + ADDR_INC;
         lane      <= '0;
      end
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      ifmap_lane u_lane (
         .clk  (clk),
         .rst  (rst),
         .clr  (init || flush),
         .load (accept && (lane == 2'(i))),
         .data (s_data),
         .q    (pack[i])
      );
   end

   always_comb begin
      state_nxt    = state;
      s_ready      = 1'b0;
      done         = 1'b0;
      BRAM_IF_EN   = 1'b0;
      BRAM_IF_WE   = 4'h0;
      BRAM_IF_ADDR = '0;
      BRAM_IF_DIN  = '0;
      case (state)
         IDLE: if (start) state_nxt = LOAD;
         LOAD: begin
            s_ready = 1'b1;
            if (accept && ((lane == 2'd3) || (pix_cnt == LAST_PIX))) state_nxt = WRITE;
         end
         WRITE: begin
            BRAM_IF_EN   = 1'b1;
            BRAM_IF_WE   = 4'hF;
            BRAM_IF_ADDR = word_addr;
            BRAM_IF_DIN  = pack;
            state_nxt    = (pix_cnt == PIX_TOTAL) ? DONE : LOAD;
         end
         DONE: begin
            done = 1'b1;
            if (start) state_nxt = LOAD;
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_ifmap_loader.sv
// Scoreboard bench for ifmap_loader: three instances (default, 6-pixel,
// wrapping base) driven with randomized handshakes against a word-level model.

module tb_ifmap_loader;
   logic        clk = 1'b0;
   logic        rst;
   logic        start   [3];
   logic        done    [3];
   logic        s_valid [3];
   logic        s_ready [3];
   logic [7:0]  s_data  [3];
   logic [31:0] addr    [3];
   logic [3:0]  we      [3];
   logic        en      [3];
   logic [31:0] din     [3];

   always #5 clk = ~clk;

   ifmap_loader u0 (
      .clk(clk), .rst(rst), .start(start[0]), .done(done[0]), .s_valid(s_valid[0]),
      .s_ready(s_ready[0]), .s_data(s_data[0]), .BRAM_IF_ADDR(addr[0]), .BRAM_IF_WE(we[0]),
      .BRAM_IF_EN(en[0]), .BRAM_IF_DIN(din[0]));

   ifmap_loader #(.NUM_PIX(6)) u1 (
      .clk(clk), .rst(rst), .start(start[1]), .done(done[1]), .s_valid(s_valid[1]),
      .s_ready(s_ready[1]), .s_data(s_data[1]), .BRAM_IF_ADDR(addr[1]), .BRAM_IF_WE(we[1]),
      .BRAM_IF_EN(en[1]), .BRAM_IF_DIN(din[1]));

   ifmap_loader #(.NUM_PIX(12), .BASE_ADDR(32'hFFFF_FFF8)) u2 (
      .clk(clk), .rst(rst), .start(start[2]), .done(done[2]), .s_valid(s_valid[2]),
      .s_ready(s_ready[2]), .s_data(s_data[2]), .BRAM_IF_ADDR(addr[2]), .BRAM_IF_WE(we[2]),
      .BRAM_IF_EN(en[2]), .BRAM_IF_DIN(din[2]));

   typedef struct {
      int          d;
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   wr_t         e;
   logic [7:0]  pix_q[$];
   logic [31:0] mem0 [256];
   logic [31:0] last_din  [3];
   logic [31:0] last_addr [3];
   int          wr_cnt [3];
   int          errors = 0;
   int          checks = 0;

   function automatic void chk(input bit ok, input string nm,
                               input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, req);
      end
   endfunction

   // Monitor: every BRAM write is popped against the expected-word queue.
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (en[d]) begin
            if (exp_q.size() == 0) begin
               chk(1'b0, "unexpected_write", {addr[d], din[d]}, 64'h0);
            end else begin
               e = exp_q.pop_front();
               chk(e.d == d && addr[d] == e.addr && din[d] == e.data && we[d] == 4'hF,
                   "bram_write", {addr[d], din[d]}, {e.addr, e.data});
            end
            wr_cnt[d]++;
            last_din[d]  = din[d];
            last_addr[d] = addr[d];
            if (d == 0) mem0[addr[0][9:2]] = din[0];
         end else begin
            chk(we[d] == 4'h0 && addr[d] == 32'h0 && din[d] == 32'h0,
                "idle_bram_outputs", {28'h0, we[d], addr[d]}, 64'h0);
         end
      end
   end

   // mode 0: k mod 256, mode 1: k+1, mode 2: random bytes
   task automatic run_frame(input int d, input int npix, input logic [31:0] base,
                            input int mode, input int duty, input bit noise, input int lim);
      int          acc, guard, nwords, idx;
      logic [31:0] wd;
      bit          prev_done, fire;
      pix_q.delete();
      for (int k = 0; k < npix; k++)
         pix_q.push_back(mode == 0 ? 8'(k) : mode == 1 ? 8'(k + 1) : 8'($urandom));
      nwords = (lim >= npix) ? (npix + 3) / 4 : lim / 4;
      for (int w = 0; w < nwords; w++) begin
         wd = 32'h0;
         for (int b = 0; b < 4; b++) begin
            idx = 4 * w + b;
            if (idx < npix) wd[8*b +: 8] = pix_q[idx];
         end
         exp_q.push_back('{d, 32'(base + 32'(w * 4)), wd});
      end
      @(negedge clk);
      prev_done = done[d];
      start[d] = 1'b1;
      @(negedge clk);
      start[d] = 1'b0;
      if (prev_done) chk(done[d] == 1'b0, "done_clears_after_start", 64'(done[d]), 64'h0);
      chk(s_ready[d] == 1'b1, "load_entry_ready", 64'(s_ready[d]), 64'h1);
      acc = 0;
      guard = 0;
      while (acc < lim) begin
         s_valid[d] = ($urandom_range(99) < duty);
         // garbage while not ready: any acceptance would corrupt the image
         s_data[d]  = s_ready[d] ? pix_q[acc] : 8'($urandom);
         start[d]   = noise && ($urandom_range(15) == 0);
         fire = s_valid[d] && s_ready[d];
         @(negedge clk);
         if (fire) acc++;
         guard++;
         if (guard > 20000) begin
            chk(1'b0, "stream_timeout", 64'(acc), 64'(lim));
            break;
         end
      end
      s_valid[d] = 1'b0;
      start[d]   = 1'b0;
   endtask

   task automatic wait_done(input int d);
      int n = 0;
      while (!done[d] && n < 6000) begin
         @(negedge clk);
         n++;
      end
      chk(done[d] == 1'b1, "done_level", 64'(done[d]), 64'h1);
      chk(s_ready[d] == 1'b0, "done_not_ready", 64'(s_ready[d]), 64'h0);
      chk(exp_q.size() == 0, "all_words_written", 64'(exp_q.size()), 64'h0);
   endtask

   task automatic clear_mem0();
      for (int i = 0; i < 256; i++) mem0[i] = 32'hDEAD_BEEF;
   endtask

   task automatic check_mem0(input string nm);
      logic [31:0] w;
      int bad = 0;
      for (int i = 0; i < 256; i++) begin
         w = {pix_q[4*i+3], pix_q[4*i+2], pix_q[4*i+1], pix_q[4*i]};
         if (mem0[i] !== w) begin
            if (bad == 0) chk(1'b0, nm, {32'(i), mem0[i]}, {32'(i), w});
            bad++;
         end
      end
      if (bad == 0) chk(1'b1, nm, 64'h0, 64'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      int c0;
      rst = 1'b0;
      for (int d = 0; d < 3; d++) begin
         start[d] = 1'b0; s_valid[d] = 1'b0; s_data[d] = 8'h0; wr_cnt[d] = 0;
      end
      clear_mem0();
      #1;
      for (int d = 0; d < 3; d++)
         chk({en[d], we[d], addr[d], din[d], s_ready[d], done[d]} == '0,
             "reset_outputs", {32'h0, addr[d] | din[d]}, 64'h0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk(s_ready[0] == 1'b0 && done[0] == 1'b0, "idle_after_reset",
          {s_ready[0], done[0]}, 64'h0);

      // full frame, continuous valid, ramp data
      run_frame(0, 1024, 32'h0, 0, 100, 1'b0, 1024);
      wait_done(0);
      chk(wr_cnt[0] == 256, "frame_word_count", 64'(wr_cnt[0]), 64'd256);
      chk(mem0[0] == 32'h0302_0100, "word0", 64'(mem0[0]), 64'h0302_0100);
      chk(mem0[255] == 32'hFFFE_FDFC, "word255", 64'(mem0[255]), 64'hFFFE_FDFC);
      check_mem0("mem_image_ramp");

      // same ramp with ~50% valid gaps and start pulses during load
      clear_mem0();
      c0 = wr_cnt[0];
      run_frame(0, 1024, 32'h0, 0, 50, 1'b1, 1024);
      wait_done(0);
      chk(wr_cnt[0] - c0 == 256, "gapped_word_count", 64'(wr_cnt[0] - c0), 64'd256);
      check_mem0("mem_image_gapped");

      // restart from DONE with random data overwrites from base
      clear_mem0();
      run_frame(0, 1024, 32'h0, 2, 70, 1'b1, 1024);
      wait_done(0);
      check_mem0("mem_image_second_frame");

      // 6-pixel frame: one full word and one zero-padded partial word
      c0 = wr_cnt[1];
      run_frame(1, 6, 32'h0, 1, 100, 1'b0, 6);
      wait_done(1);
      chk(wr_cnt[1] - c0 == 2, "short_word_count", 64'(wr_cnt[1] - c0), 64'd2);
      chk(last_din[1] == 32'h0000_0605, "partial_word", 64'(last_din[1]), 64'h605);
      chk(last_addr[1] == 32'h4, "partial_addr", 64'(last_addr[1]), 64'h4);
      for (int r = 0; r < 4; r++) begin
         run_frame(1, 6, 32'h0, 2, 40, 1'b1, 6);
         wait_done(1);
      end

      // base near the top of the address space wraps to 0
      c0 = wr_cnt[2];
      run_frame(2, 12, 32'hFFFF_FFF8, 2, 60, 1'b1, 12);
      wait_done(2);
      chk(wr_cnt[2] - c0 == 3, "wrap_word_count", 64'(wr_cnt[2] - c0), 64'd3);
      chk(last_addr[2] == 32'h0, "wrap_addr", 64'(last_addr[2]), 64'h0);

      // reset after pixel 2 of word 5: words 0..4 only, then reload from base
      c0 = wr_cnt[0];
      run_frame(0, 1024, 32'h0, 2, 100, 1'b0, 23);
      rst = 1'b0;
      #1;
      chk({en[0], we[0], addr[0], din[0], s_ready[0], done[0]} == '0,
          "midframe_reset_outputs", {addr[0], din[0]}, 64'h0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk(wr_cnt[0] - c0 == 5, "abandoned_word_count", 64'(wr_cnt[0] - c0), 64'd5);
      chk(exp_q.size() == 0, "no_pending_after_reset", 64'(exp_q.size()), 64'h0);
      chk(s_ready[0] == 1'b0 && done[0] == 1'b0, "idle_wait_after_reset",
          {s_ready[0], done[0]}, 64'h0);
      clear_mem0();
      run_frame(0, 1024, 32'h0, 2, 50, 1'b0, 1024);
      wait_done(0);
      check_mem0("mem_image_after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ifmap_loader.md
IFMAP_LOADER -- requirements
Module: ifmap_loader

Interface
REQ-001 Parameter NUM_PIX, default 1024, SHALL set the number of 8-bit pixels loaded per frame (32x32 input map); legal range 1..65535.
REQ-002 Parameter BASE_ADDR, default 32'h0, SHALL set the BRAM_IF byte address of the first word written.
REQ-003 Parameter ADDR_INC, default 4, SHALL set the byte-address increment between consecutive words.
REQ-004 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse that begins a frame load.
REQ-007 done  output  1  level; high from frame completion until the next accepted start.
REQ-008 s_valid  input  1  upstream pixel valid.
REQ-009 s_ready  output  1  loader can accept a pixel this cycle.
REQ-010 s_data  input  8  pixel byte, unsigned.
REQ-011 BRAM_IF_ADDR  output  32  byte address of the write port.
REQ-012 BRAM_IF_WE  output  4  byte-lane write enables.
REQ-013 BRAM_IF_EN  output  1  BRAM port enable.
REQ-014 BRAM_IF_DIN  output  32  write data.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, WRITE, DONE.
REQ-016 IDLE: s_ready=0, done=0; start=1 -> LOAD, pixel count=0, lane=0, word address=BASE_ADDR, pack buffer=0.
REQ-017 LOAD: s_ready=1; a pixel SHALL be accepted only when s_valid=1 and s_ready=1 in the same cycle; s_data is ignored otherwise.
REQ-018 Pixel k of a frame SHALL be packed into byte lane k mod 4 (pixel 0 -> DIN[7:0], pixel 3 -> DIN[31:24]).
REQ-019 LOAD -> WRITE on the cycle a pixel is accepted into lane 3, or on acceptance of pixel NUM_PIX-1, whichever comes first.
REQ-020 WRITE: lasts exactly one cycle; BRAM_IF_EN=1, BRAM_IF_WE=4'hF, BRAM_IF_ADDR=current word address, BRAM_IF_DIN=pack buffer; s_ready=0.
REQ-021 Unfilled lanes of a final partial word SHALL be written as 8'h00.
REQ-022 Leaving WRITE: word address += ADDR_INC, lane=0, pack buffer=0; -> DONE if NUM_PIX pixels accepted, else -> LOAD.
REQ-023 Latency: a word SHALL be driven to BRAM in the cycle immediately after its last pixel is accepted.
REQ-024 Address SHALL wrap modulo 2^32; no other bound checking.
REQ-025 DONE: done=1, s_ready=0; start=1 -> LOAD with the same initialisation as REQ-016, done deasserting in that next cycle.
REQ-026 start SHALL be ignored in LOAD and WRITE.
REQ-027 Outside WRITE, BRAM_IF_EN=0, BRAM_IF_WE=4'h0, BRAM_IF_DIN=0, BRAM_IF_ADDR=0.
REQ-028 Total words written per frame SHALL equal ceil(NUM_PIX/4), at addresses BASE_ADDR + i*ADDR_INC.

Reset
REQ-029 rst=0 SHALL immediately force IDLE, counters/buffer/address to 0, and all outputs to 0, irrespective of clk.
REQ-030 Reset mid-frame SHALL abandon the frame; no partial word SHALL be written, and after release the block waits in IDLE for start.

Verification
REQ-031 NUM_PIX=1024, start, bytes 0x00..0xFF repeating with s_valid held 1 -> 256 writes, word0=32'h03020100 @0, word255=32'hFFFEFDFC @1020, done=1, bram.mem[0..255] match.
REQ-032 NUM_PIX=6, bytes 01..06 -> exactly two writes: 32'h04030201 @0, 32'h00000605 @4; then done=1.
REQ-033 Random s_valid gaps (~50% duty), NUM_PIX=1024 -> identical memory image to REQ-031; no byte accepted while s_ready=0.
REQ-034 rst=0 asserted after pixel 2 of word 5 -> all outputs 0 same cycle, no write for word 5; start after release reloads from BASE_ADDR.
REQ-035 start pulsed during LOAD -> no effect on count/address; start in DONE -> done=0 next cycle and second frame overwrites from BASE_ADDR.
REQ-036 BASE_ADDR=32'hFFFF_FFF8, NUM_PIX=12 -> writes at FFFFFFF8, FFFFFFFC, 00000000.
